example_producer: RTL and testbench

EXAMPLE_PRODUCER -- requirements
Module: example_producer

---
 rtl/example_producer_pkg.sv | 20 ++
 rtl/example_producer.sv | 99 +++++++++
 tb/tb_example_producer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/example_producer_pkg.sv
// Shared definitions for the example stream producer: generation modes, FSM states
// and the beat data pattern.
package example_producer_pkg;

    localparam int DISABLED  = 0;
    localparam int COUNTER   = 1;
    localparam int THROTTLED = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Beat k carries its own index in the low word and the complement in the high word.
    function automatic logic [63:0] beat_data(input logic [31:0] k);
        return {~k, k};
    endfunction

endpackage

// File: rtl/example_producer.sv
// Burst stream producer: on start emits count_in beats of {~k, k}, either back-to-back
// or separated by GAP idle cycles, then pulses done_out.
module example_producer
    import example_producer_pkg::*;
#(
    parameter int MODE = COUNTER,
    parameter int GAP  = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic [31:0] count_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [63:0] f2cData_out,
    output logic        f2cValid_out,
    input  logic        f2cReady_in,
    output state_t      state_out
);

    localparam logic [7:0] GAP_CYCLES = 8'(GAP);

    state_t      state;
    logic [31:0] remaining;
    logic [31:0] k;
    logic [7:0]  gap_cnt;
    logic [31:0] k_next;

    assign k_next    = k + 32'd1;
    assign state_out = state;

    // Handshake: a beat transfers on any rising edge where f2cValid_out and f2cReady_in
    // are both high; valid and data are registered and held until that transfer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= S_IDLE;
            remaining    <= 32'd0;
            k            <= 32'd0;
            gap_cnt      <= 8'd0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            f2cValid_out <= 1'b0;
            f2cData_out  <= 64'd0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_in && (MODE != DISABLED)) begin
                        if (count_in == 32'd0) begin
                            done_out <= 1'b1;
                        end else begin
                            remaining    <= count_in;
                            k            <= 32'd0;
                            busy_out     <= 1'b1;
                            f2cValid_out <= 1'b1;
                            f2cData_out  <= beat_data(32'd0);
                            state        <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (f2cReady_in) begin
                        k <= k_next;
                        if (remaining == 32'd1) begin
                            busy_out     <= 1'b0;
                            done_out     <= 1'b1;
                            f2cValid_out <= 1'b0;
                            f2cData_out  <= 64'd0;
                            state        <= S_IDLE;
                        end else begin
                            remaining <= remaining - 32'd1;
                            if (MODE == THROTTLED) begin
                                gap_cnt      <= GAP_CYCLES;
                                f2cValid_out <= 1'b0;
                                f2cData_out  <= 64'd0;
                                state        <= S_GAP;
                            end else begin
                                f2cData_out <= beat_data(k_next);
                            end
                        end
                    end
                end
                S_GAP: begin
                    // gap_cnt counts the idle cycles still to come, including this one.
                    if (gap_cnt == 8'd1) begin
                        gap_cnt      <= 8'd0;
                        f2cValid_out <= 1'b1;
                        f2cData_out  <= beat_data(k);
                        state        <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_example_producer.sv
// Bench for example_producer: COUNTER, THROTTLED (GAP=4) and DISABLED instances driven
// from directed and random bursts, checked against an expected-beat queue per instance.
module tb_example_producer;
    import example_producer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_c, start_t, start_d;
    logic [31:0] count;
    logic        ready;

    logic        busy_c, done_c, valid_c;
    logic        busy_t, done_t, valid_t;
    logic        busy_d, done_d, valid_d;
    logic [63:0] data_c, data_t, data_d;
    state_t      state_c, state_t_o, state_d;

    logic [63:0] exp_c[$];
    logic [63:0] exp_t[$];
    int n_tests = 0;
    int n_fail = 0;
    int nd_c = 0, nd_t = 0, exp_done_c = 0, exp_done_t = 0;

    always #5 clk = ~clk;

    example_producer #(.MODE(COUNTER), .GAP(4)) dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_c), .count_in(count),
        .busy_out(busy_c), .done_out(done_c), .f2cData_out(data_c),
        .f2cValid_out(valid_c), .f2cReady_in(ready), .state_out(state_c)
    );

    example_producer #(.MODE(THROTTLED), .GAP(4)) dut_t (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_t), .count_in(count),
        .busy_out(busy_t), .done_out(done_t), .f2cData_out(data_t),
        .f2cValid_out(valid_t), .f2cReady_in(ready), .state_out(state_t_o)
    );

    example_producer #(.MODE(DISABLED), .GAP(4)) dut_d (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_d), .count_in(count),
        .busy_out(busy_d), .done_out(done_d), .f2cData_out(data_d),
        .f2cValid_out(valid_d), .f2cReady_in(ready), .state_out(state_d)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {~kk, kk};
    endfunction

    // Monitors: pop the scoreboard on every transfer, check hold and zero-data rules.
    logic        pv_c = 1'b0, pr_c = 1'b0;
    logic [63:0] pd_c = 64'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_c = 1'b0;
        end else begin
            if (pv_c && !pr_c) begin
                check_eq("c_hold_valid", 64'(valid_c), 64'd1);
                check_eq("c_hold_data", data_c, pd_c);
            end
            if (valid_c && ready) begin
                if (exp_c.size() == 0) check_eq("c_extra_beat", 64'(exp_c.size()), 64'd1);
                else check_eq("c_beat", data_c, exp_c.pop_front());
            end
            if (!valid_c) check_eq("c_idle_data", data_c, 64'd0);
            if (done_c) nd_c++;
            pv_c = valid_c;
            pr_c = ready;
            pd_c = data_c;
        end
    end

    logic        pv_t = 1'b0, pr_t = 1'b0;
    logic [63:0] pd_t = 64'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_t = 1'b0;
        end else begin
            if (pv_t && !pr_t) begin
                check_eq("t_hold_valid", 64'(valid_t), 64'd1);
                check_eq("t_hold_data", data_t, pd_t);
            end
            if (valid_t && ready) begin
                if (exp_t.size() == 0) check_eq("t_extra_beat", 64'(exp_t.size()), 64'd1);
                else check_eq("t_beat", data_t, exp_t.pop_front());
            end
            if (!valid_t) check_eq("t_idle_data", data_t, 64'd0);
            if (done_t) nd_t++;
            pv_t = valid_t;
            pr_t = ready;
            pd_t = data_t;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_c(input int n);
        start_c = 1'b1;
        count   = 32'(n);
        for (int i = 0; i < n; i++) exp_c.push_back(beat(i));
        exp_done_c++;
        next_cycle();
        start_c = 1'b0;
    endtask

    task automatic go_t(input int n);
        start_t = 1'b1;
        count   = 32'(n);
        for (int i = 0; i < n; i++) exp_t.push_back(beat(i));
        exp_done_t++;
        next_cycle();
        start_t = 1'b0;
    endtask

    task automatic drain_c(input int budget, input bit rnd);
        int cyc = 0;
        while ((exp_c.size() != 0 || busy_c || done_c) && cyc < budget) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            next_cycle();
            cyc++;
        end
        ready = 1'b1;
        check_eq("c_drain_in_budget", 64'(cyc < budget), 64'd1);
        check_eq("c_done_count", 64'(nd_c), 64'(exp_done_c));
    endtask

    task automatic drain_t(input int budget, input bit rnd);
        int cyc = 0;
        while ((exp_t.size() != 0 || busy_t || done_t) && cyc < budget) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            next_cycle();
            cyc++;
        end
        ready = 1'b1;
        check_eq("t_drain_in_budget", 64'(cyc < budget), 64'd1);
        check_eq("t_done_count", 64'(nd_t), 64'(exp_done_t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start_c = 1'b0;
        start_t = 1'b0;
        start_d = 1'b0;
        count   = 32'd0;
        ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(valid_c), 64'd0);
        check_eq("rst_busy", 64'(busy_c), 64'd0);
        check_eq("rst_done", 64'(done_c), 64'd0);
        check_eq("rst_data", data_c, 64'd0);
        check_eq("rst_state", 64'(state_c), 64'(S_IDLE));
        #2 rst_n = 1'b1;
        next_cycle();

        // Four back-to-back beats, done on cycle 5.
        go_c(4);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_eq("t1_valid", 64'(valid_c), 64'(i <= 4));
            check_eq("t1_busy", 64'(busy_c), 64'(i <= 4));
            if (i <= 4) check_eq("t1_data", data_c, beat(i - 1));
            check_eq("t1_done", 64'(done_c), 64'(i == 5));
            next_cycle();
        end

        // Restart on the cycle done is high.
        go_c(1);
        @(negedge clk);
        check_eq("b2b_valid1", 64'(valid_c), 64'd1);
        next_cycle();
        check_eq("b2b_done", 64'(done_c), 64'd1);
        go_c(2);
        @(negedge clk);
        check_eq("b2b_valid2", 64'(valid_c), 64'd1);
        check_eq("b2b_data2", data_c, beat(0));
        drain_c(50, 1'b0);

        // Backpressure: ready low for cycles 1-3.
        ready = 1'b0;
        go_c(3);
        for (int i = 1; i <= 7; i++) begin
            ready = (i >= 4);
            @(negedge clk);
            check_eq("t2_valid", 64'(valid_c), 64'(i <= 6));
            if (i <= 6) check_eq("t2_data", data_c, beat((i <= 4) ? 0 : i - 4));
            check_eq("t2_done", 64'(done_c), 64'(i == 7));
            next_cycle();
        end
        ready = 1'b1;

        // Throttled: valid at 1, 6, 11; done at 12.
        go_t(3);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check_eq("t3_valid", 64'(valid_t), 64'(i == 1 || i == 6 || i == 11));
            if (i == 1 || i == 6 || i == 11) check_eq("t3_data", data_t, beat((i - 1) / 5));
            check_eq("t3_busy", 64'(busy_t), 64'(i <= 11));
            check_eq("t3_done", 64'(done_t), 64'(i == 12));
            next_cycle();
        end

        // Zero-length burst, then a start pulsed mid-burst that must be ignored.
        go_c(0);
        @(negedge clk);
        check_eq("t4_zero_done", 64'(done_c), 64'd1);
        check_eq("t4_zero_valid", 64'(valid_c), 64'd0);
        check_eq("t4_zero_busy", 64'(busy_c), 64'd0);
        next_cycle();
        go_c(5);
        start_c = 1'b1;
        count   = 32'd7;
        next_cycle();
        start_c = 1'b0;
        drain_c(50, 1'b0);

        // Reset mid-burst after beat 2.
        go_c(10);
        next_cycle();
        next_cycle();
        @(negedge clk);
        next_cycle();
        rst_n = 1'b0;
        exp_c.delete();
        exp_done_c--;
        #1;
        check_eq("t5_rst_valid", 64'(valid_c), 64'd0);
        check_eq("t5_rst_data", data_c, 64'd0);
        check_eq("t5_rst_busy", 64'(busy_c), 64'd0);
        check_eq("t5_rst_done", 64'(done_c), 64'd0);
        check_eq("t5_rst_state", 64'(state_c), 64'(S_IDLE));
        @(negedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        go_c(2);
        @(negedge clk);
        check_eq("t5_restart_data", data_c, beat(0));
        drain_c(50, 1'b0);

        // Disabled instance ignores start.
        start_d = 1'b1;
        count   = 32'd8;
        next_cycle();
        start_d = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("t6_disabled_outs", {61'd0, valid_d, busy_d, done_d}, 64'd0);
            check_eq("t6_disabled_data", data_d, 64'd0);
            next_cycle();
        end

        // Random bursts with random backpressure.
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, 6);
            if (it % 2 == 0) begin
                go_c(n);
                drain_c(300, 1'b1);
            end else begin
                go_t(n);
                drain_t(400, 1'b1);
            end
        end

        check_eq("end_queue_c", 64'(exp_c.size()), 64'd0);
        check_eq("end_queue_t", 64'(exp_t.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
